// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory, redirect and decode-stage handshake bundle
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] RI;
    logic [31:0] pc_out;
    logic [2:0]  ImmSel;
    modport master (
        output imem_req, imem_addr, out_valid, RI, pc_out, ImmSel,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, RI, pc_out, ImmSel,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch FSM with redirect, response drop and immediate-type decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ri_q, ri_d, pc_out_q, pc_out_d;
    logic [2:0]  imm_sel_q, imm_sel_d;
    logic        out_valid_q, out_valid_d, accept;

    function automatic logic [2:0] decode(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: decode = 3'b000;
            7'b0100011:                                     decode = 3'b001;
            7'b1100011:                                     decode = 3'b010;
            7'b0110111, 7'b0010111:                         decode = 3'b011;
            7'b1101111:                                     decode = 3'b100;
            default:                                        decode = 3'b111;
        endcase
    endfunction

    always_comb begin
        accept      = state_q == WAIT && bus.imem_rvalid && !bus.redirect;
        ri_d        = accept ? bus.imem_rdata : ri_q;
        pc_out_d    = accept ? pc_q : pc_out_q;
        imm_sel_d   = accept ? decode(bus.imem_rdata[6:0]) : imm_sel_q;
        pc_d        = bus.redirect ? (bus.redirect_pc & ~32'h3) : accept ? pc_q + 32'd4 : pc_q;
        out_valid_d = bus.redirect ? 1'b0 : accept ? 1'b1 :
                      (state_q == HOLD && bus.out_ready) ? 1'b0 : out_valid_q;
        state_d     = state_q;
        // A redirect with a request still in flight must drain it in DROP
        case (state_q)
            FETCH: state_d = bus.redirect ? DROP : WAIT;
            WAIT:  state_d = bus.imem_rvalid ? (bus.redirect ? FETCH : HOLD) : (bus.redirect ? DROP : WAIT);
            HOLD:  state_d = (bus.redirect || bus.out_ready) ? FETCH : HOLD;
            DROP:  state_d = bus.imem_rvalid ? FETCH : DROP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC & ~32'h3;
            ri_q        <= '0;
            pc_out_q    <= '0;
            imm_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ri_q        <= ri_d;
            pc_out_q    <= pc_out_d;
            imm_sel_q   <= imm_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.imem_req  = state_q == FETCH && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.RI        = ri_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.ImmSel    = imm_sel_q;
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory read request, one cycle wide.
REQ-005 imem_addr  output  32  read address, equal to current PC.
REQ-006 imem_rvalid  input  1  read data valid, any cycle after request.
REQ-007 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-008 redirect  input  1  branch/jump redirect, one cycle.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 out_valid  output  1  RI/pc_out/ImmSel hold a valid instruction.
REQ-011 out_ready  input  1  downstream accepts instruction this cycle.
REQ-012 RI  output  32  registered instruction word, feeds immediate generator.
REQ-013 pc_out  output  32  PC of instruction in RI.
REQ-014 ImmSel  output  3  registered immediate-type select for RI.

Function
REQ-015 States: FETCH, WAIT, HOLD, DROP; one outstanding memory request at most.
REQ-016 FETCH: imem_req=1, imem_addr=pc; next state WAIT unconditionally (memory accepts every request).
REQ-017 WAIT: imem_req=0; on imem_rvalid: RI<=imem_rdata, pc_out<=pc, ImmSel<=decode(imem_rdata[6:0]), pc<=pc+4, out_valid<=1, -> HOLD; else stay.
REQ-018 HOLD: out_valid=1, RI/pc_out/ImmSel stable; on out_ready: out_valid<=0, -> FETCH.
REQ-019 DROP: imem_req=0; wait for in-flight response; on imem_rvalid discard data, -> FETCH.
REQ-020 redirect=1 in any state: pc<={redirect_pc[31:2],2'b00}, out_valid<=0; redirect overrides out_ready and imem_rvalid in same cycle.
REQ-021 Redirect next state: FETCH -> DROP; WAIT without rvalid -> DROP; WAIT with rvalid -> FETCH (data discarded); HOLD -> FETCH; DROP without rvalid -> DROP; DROP with rvalid -> FETCH.
REQ-022 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc[1:0] always 0.
REQ-023 Decode: 0010011, 0000011, 1100111, 1110011 -> 3'b000 (I); 0100011 -> 3'b001 (S); 1100011 -> 3'b010 (B); 0110111, 0010111 -> 3'b011 (U); 1101111 -> 3'b100 (J); all other opcodes -> 3'b111.
REQ-024 Minimum latency: imem_req to out_valid = rvalid latency + 1 cycle; back-to-back throughput with 1-cycle memory and out_ready=1 = one instruction per 3 cycles.
REQ-025 imem_rvalid in FETCH or HOLD (protocol violation) ignored; no state or data change.

Reset
REQ-026 While rst=1: state=FETCH, pc=RESET_PC, out_valid=0, RI=32'h0000_0000, pc_out=32'h0000_0000, ImmSel=3'b000, imem_req=0.
REQ-027 First imem_req=1 (addr RESET_PC) in first cycle after rst deasserts; rst asserted mid-request abandons it, late imem_rvalid during reset ignored; first response after reset release accepted only from WAIT.

Verification
REQ-028 Reset release, 1-cycle memory returning 32'h0050_0093, out_ready=1 -> imem_addr=0, next cycle WAIT, RI=32'h0050_0093, pc_out=0, ImmSel=000, out_valid=1; next request addr 4.
REQ-029 Opcode sweep: rdata 0x00112023, 0x00208463, 0x123452B7, 0x008000EF, 0x002081B3 -> ImmSel 001, 010, 011, 100, 111.
REQ-030 Backpressure: out_ready=0 for 5 cycles in HOLD -> RI/pc_out/ImmSel stable, imem_req=0 throughout; out_ready=1 -> FETCH at addr pc_out+4.
REQ-031 Redirect to 32'h0000_0103 in WAIT, rvalid 2 cycles later -> DROP, response discarded, out_valid stays 0, next imem_addr=32'h0000_0100.
REQ-032 RESET_PC=32'hFFFF_FFFC, one fetch completed -> pc_out=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-033 Redirect and imem_rvalid same cycle in WAIT -> no out_valid, next cycle FETCH at redirect target.
